// File: rtl/data_mem_slave.sv
// Single-port data memory on the core's req/gnt/rvalid port: one transaction in flight,
// byte-enabled stores, configurable grant wait states and a fixed read latency.
module data_mem_slave #(
  parameter int    ADDR_WIDTH = 12,
  parameter int    DATA_WIDTH = 32,
  parameter int    BE_WIDTH   = 4,
  parameter int    GNT_WAIT   = 0,
  parameter int    RD_LATENCY = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_wr_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  proto_err_o
);

  localparam int         DEPTH     = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] LAT_LOAD  = 4'(RD_LATENCY - 1);
  localparam logic [3:0] WAIT_LOAD = 4'((GNT_WAIT > 0) ? (GNT_WAIT - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    wr_q;
  logic [DATA_WIDTH-1:0]   word_q;
  logic                    rvalid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    perr_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    grant_d;
  logic [ADDR_WIDTH-3:0]   idx_d;
  logic                    unused_addr_lsb;

  assign idx_d           = data_addr_i[ADDR_WIDTH-1:2];
  assign unused_addr_lsb = ^data_addr_i[1:0];

  // Grant follows req directly once the wait phase (if any) has counted out
  always_comb begin
    grant_d = 1'b0;
    if (rst) begin
      grant_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: grant_d = (GNT_WAIT == 0) ? data_req_i : 1'b0;
        ST_WAIT: grant_d = (cnt_q == 4'd0) ? data_req_i : 1'b0;
        default: grant_d = 1'b0;
      endcase
    end
  end

  // Store commit on the grant edge, lane by lane; not touched by reset
  always_ff @(posedge clk) begin
    if (grant_d && data_wr_i) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (data_be_i[i]) begin
          mem[idx_d][8*i +: 8] <= data_wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Transaction FSM; rvalid/rdata are loaded one cycle ahead so they leave a register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      wr_q     <= 1'b0;
      word_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      perr_q   <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      if (grant_d) begin
        state_q <= ST_RESP;
        cnt_q   <= LAT_LOAD;
        wr_q    <= data_wr_i;
        word_q  <= mem[idx_d];
        if (LAT_LOAD == 4'd0) begin
          rvalid_q <= 1'b1;
          rdata_q  <= data_wr_i ? '0 : mem[idx_d];
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (data_req_i && (GNT_WAIT != 0)) begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_LOAD;
            end
          end
          ST_WAIT: begin
            // Dropping req before the grant is a protocol error; the request is abandoned
            if (!data_req_i) begin
              perr_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          ST_RESP: begin
            if (cnt_q == 4'd0) begin
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q - 4'd1;
              if (cnt_q == 4'd1) begin
                rvalid_q <= 1'b1;
                rdata_q  <= wr_q ? '0 : word_q;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign data_gnt_o    = grant_d;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign proto_err_o   = perr_q;

endmodule

// File: tb/tb_data_mem_slave.sv
// Bench for data_mem_slave: four instances with different wait/latency settings, a
// transaction-level model checked every cycle, plus directed literal expectations.
module tb_data_mem_slave;

  localparam int N = 4;

  function automatic int gw_of(input int k);
    case (k)
      1:       return 2;
      2:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int rl_of(input int k);
    case (k)
      1:       return 3;
      3:       return 4;
      default: return 1;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst   [N];
  logic        req   [N];
  logic [11:0] addr  [N];
  logic        wr    [N];
  logic [3:0]  be    [N];
  logic [31:0] wdata [N];
  logic        gnt   [N];
  logic        rv    [N];
  logic [31:0] rd    [N];
  logic        perr  [N];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < N; k++) begin : g_dut
    data_mem_slave #(
      .ADDR_WIDTH(12), .DATA_WIDTH(32), .BE_WIDTH(4),
      .GNT_WAIT(gw_of(k)), .RD_LATENCY(rl_of(k)), .INIT_FILE("")
    ) u_dut (
      .clk(clk), .rst(rst[k]),
      .data_req_i(req[k]), .data_gnt_o(gnt[k]), .data_addr_i(addr[k]),
      .data_wr_i(wr[k]), .data_be_i(be[k]), .data_wdata_i(wdata[k]),
      .data_rvalid_o(rv[k]), .data_rdata_o(rd[k]), .proto_err_o(perr[k])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: a request starting in an idle slot is granted GNT_WAIT
  // cycles later, answered RD_LATENCY cycles after that, and the next slot opens after it.
  int          m_start [N];
  int          m_free  [N];
  int          m_due   [N];
  bit          m_en    [N];
  bit          m_perr  [N];
  bit          m_known [N];
  logic [31:0] m_data  [N];
  logic [31:0] mm [N][1024];
  bit          mv [N][1024];

  task automatic model_step(input int k);
    int c;
    int idx;
    bit eg;
    bit erv;
    bit perr_set;
    logic [31:0] erd;
    bit rd_known;
    c = cyc;
    eg = 1'b0;
    perr_set = 1'b0;
    erv = (m_due[k] == c);
    erd = (erv && m_known[k]) ? m_data[k] : 32'h0;
    rd_known = !erv || m_known[k];
    if (rst[k] !== 1'b0) begin
      if (m_en[k]) begin
        check($sformatf("gnt[%0d]", k), {31'b0, gnt[k]}, 32'd0);
        check($sformatf("rvalid[%0d]", k), {31'b0, rv[k]}, {31'b0, erv});
        check($sformatf("perr[%0d]", k), {31'b0, perr[k]}, {31'b0, m_perr[k]});
      end
      m_en[k] = 1'b1;
      m_start[k] = -1;
      m_due[k] = -1;
      m_free[k] = c + 1;
      m_perr[k] = 1'b0;
      return;
    end
    if (!m_en[k]) return;
    if (m_start[k] < 0 && c >= m_free[k] && req[k] === 1'b1) m_start[k] = c;
    if (m_start[k] >= 0) begin
      if (req[k] !== 1'b1) begin
        perr_set = 1'b1;
        m_start[k] = -1;
        m_free[k] = c + 1;
      end else if (c == m_start[k] + gw_of(k)) begin
        eg = 1'b1;
        idx = int'(addr[k][11:2]);
        if (wr[k]) begin
          for (int i = 0; i < 4; i++) begin
            if (be[k][i]) mm[k][idx][8*i +: 8] = wdata[k][8*i +: 8];
          end
          if (be[k] == 4'hF) mv[k][idx] = 1'b1;
          m_known[k] = 1'b1;
          m_data[k] = 32'h0;
        end else begin
          m_known[k] = mv[k][idx];
          m_data[k] = mm[k][idx];
        end
        m_due[k] = c + rl_of(k);
        m_free[k] = c + rl_of(k) + 1;
        m_start[k] = -1;
      end
    end
    check($sformatf("gnt[%0d]", k), {31'b0, gnt[k]}, {31'b0, eg});
    check($sformatf("rvalid[%0d]", k), {31'b0, rv[k]}, {31'b0, erv});
    if (rd_known) check($sformatf("rdata[%0d]", k), rd[k], erd);
    check($sformatf("perr[%0d]", k), {31'b0, perr[k]}, {31'b0, m_perr[k]});
    if (perr_set) m_perr[k] = 1'b1;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) model_step(k);
  end

  task automatic drive(input int k, input bit w, input logic [11:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    req[k] = 1'b1; wr[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
  endtask

  task automatic wait_gnt(input int k, output int gc);
    gc = -1;
    for (int i = 0; i < 40 && gc < 0; i++) begin
      @(negedge clk);
      if (gnt[k] === 1'b1) gc = cyc;
    end
    if (gc < 0) begin
      n_assert++; n_fail++;
      $display("FAIL gnt_timeout[%0d]: no grant within 40 cycles", k);
    end
  endtask

  task automatic wait_rv(input int k, output int rc, output logic [31:0] data);
    rc = -1;
    data = 32'h0;
    for (int i = 0; i < 40 && rc < 0; i++) begin
      @(negedge clk);
      if (rv[k] === 1'b1) begin
        rc = cyc;
        data = rd[k];
      end
    end
    if (rc < 0) begin
      n_assert++; n_fail++;
      $display("FAIL rv_timeout[%0d]: no rvalid within 40 cycles", k);
    end
  endtask

  // One full transaction: returns request, grant and response cycles plus response data
  task automatic xact(input int k, input bit w, input logic [11:0] a, input logic [3:0] b,
                      input logic [31:0] d, output int qc, output int gc, output int rc,
                      output logic [31:0] data);
    @(posedge clk); #1;
    drive(k, w, a, b, d);
    qc = cyc;
    wait_gnt(k, gc);
    @(posedge clk); #1;
    req[k] = 1'b0;
    wait_rv(k, rc, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q, g, r, ng, nr, nrv;
    logic [31:0] d;
    int gcs [3];
    int rcs [3];
    logic [31:0] rds [3];
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; addr[k] = 12'h0;
      wr[k] = 1'b0; be[k] = 4'h0; wdata[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check("reset_gnt", {31'b0, gnt[k]}, 32'd0);
      check("reset_rvalid", {31'b0, rv[k]}, 32'd0);
      check("reset_rdata", rd[k], 32'h0);
      check("reset_perr", {31'b0, perr[k]}, 32'd0);
    end

    // Defaults: full store then load, then byte lanes and a misaligned load
    xact(0, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF, q, g, r, d);
    check("st_gnt_lat", g - q, 32'd0);
    check("st_rv_lat", r - g, 32'd1);
    check("st_rdata", d, 32'h0);
    xact(0, 1'b0, 12'h010, 4'h0, 32'h0, q, g, r, d);
    check("ld_rv_lat", r - g, 32'd1);
    check("ld_rdata", d, 32'hDEADBEEF);
    xact(0, 1'b1, 12'h010, 4'b0001, 32'h000000AA, q, g, r, d);
    xact(0, 1'b0, 12'h010, 4'h0, 32'h0, q, g, r, d);
    check("lane0_rdata", d, 32'hDEADBEAA);
    xact(0, 1'b1, 12'h010, 4'b1100, 32'h12340000, q, g, r, d);
    xact(0, 1'b0, 12'h010, 4'h0, 32'h0, q, g, r, d);
    check("lane32_rdata", d, 32'h1234BEAA);
    xact(0, 1'b0, 12'h013, 4'h0, 32'h0, q, g, r, d);
    check("misalign_rdata", d, 32'h1234BEAA);

    // Defaults, back-to-back loads with req held for six cycles
    xact(0, 1'b1, 12'h000, 4'hF, 32'hA0A0A0A0, q, g, r, d);
    xact(0, 1'b1, 12'h004, 4'hF, 32'hB1B1B1B1, q, g, r, d);
    xact(0, 1'b1, 12'h008, 4'hF, 32'hC2C2C2C2, q, g, r, d);
    ng = 0;
    nr = 0;
    @(posedge clk); #1;
    q = cyc;
    drive(0, 1'b0, 12'h000, 4'h0, 32'h0);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (gnt[0] === 1'b1) begin
        if (ng < 3) gcs[ng] = cyc - q;
        ng++;
      end
      if (rv[0] === 1'b1) begin
        if (nr < 3) begin
          rcs[nr] = cyc - q;
          rds[nr] = rd[0];
        end
        nr++;
      end
      @(posedge clk); #1;
      if (j == 5) req[0] = 1'b0;
      else addr[0] = 12'(ng * 4);
    end
    check("b2b_ngnt", ng, 32'd3);
    check("b2b_nrv", nr, 32'd3);
    if (ng == 3 && nr == 3) begin
      check("b2b_gnt0", gcs[0], 32'd0);
      check("b2b_gnt1", gcs[1], 32'd2);
      check("b2b_gnt2", gcs[2], 32'd4);
      check("b2b_rv0", rcs[0], 32'd1);
      check("b2b_rv1", rcs[1], 32'd3);
      check("b2b_rv2", rcs[2], 32'd5);
      check("b2b_d0", rds[0], 32'hA0A0A0A0);
      check("b2b_d1", rds[1], 32'hB1B1B1B1);
      check("b2b_d2", rds[2], 32'hC2C2C2C2);
    end

    // GNT_WAIT=2, RD_LATENCY=3
    xact(1, 1'b1, 12'h040, 4'hF, 32'h0F0F0F0F, q, g, r, d);
    check("w2_st_gnt", g - q, 32'd2);
    check("w2_st_rv", r - g, 32'd3);
    xact(1, 1'b0, 12'h040, 4'h0, 32'h0, q, g, r, d);
    check("w2_ld_gnt", g - q, 32'd2);
    check("w2_ld_rv", r - q, 32'd5);
    check("w2_ld_rdata", d, 32'h0F0F0F0F);

    // GNT_WAIT=3 with req dropped after one cycle
    @(posedge clk); #1;
    drive(2, 1'b0, 12'h000, 4'h0, 32'h0);
    @(posedge clk); #1;
    req[2] = 1'b0;
    @(negedge clk);
    check("perr_c1", {31'b0, perr[2]}, 32'd0);
    @(negedge clk);
    check("perr_c2", {31'b0, perr[2]}, 32'd1);
    repeat (4) @(negedge clk);
    xact(2, 1'b1, 12'h080, 4'hF, 32'h77665544, q, g, r, d);
    check("w3_st_gnt", g - q, 32'd3);
    xact(2, 1'b0, 12'h080, 4'h0, 32'h0, q, g, r, d);
    check("w3_ld_rdata", d, 32'h77665544);
    check("perr_sticky", {31'b0, perr[2]}, 32'd1);
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    @(negedge clk);
    check("perr_cleared", {31'b0, perr[2]}, 32'd0);

    // RD_LATENCY=4, reset two cycles after a store grant
    @(posedge clk); #1;
    drive(3, 1'b1, 12'h020, 4'hF, 32'h5A5A5A5A);
    q = cyc;
    wait_gnt(3, g);
    check("l4_st_gnt", g - q, 32'd0);
    @(posedge clk); #1;
    req[3] = 1'b0;
    @(posedge clk); #1;
    rst[3] = 1'b1;
    @(posedge clk); #1;
    rst[3] = 1'b0;
    nrv = 0;
    repeat (8) begin
      @(negedge clk);
      if (rv[3] === 1'b1) nrv++;
    end
    check("l4_dropped_rv", nrv, 32'd0);
    xact(3, 1'b0, 12'h020, 4'h0, 32'h0, q, g, r, d);
    check("l4_ld_rv", r - g, 32'd4);
    check("l4_ld_rdata", d, 32'h5A5A5A5A);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
